// File: rtl/riscv_parcel_queue.sv
// rtl/riscv_parcel_queue.sv - parcel FIFO that re-assembles fetch words into RVC/32-bit instructions
module riscv_parcel_queue #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 16,
  parameter int HAS_RVC     = 1,
  parameter int DEPTH       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  output logic                      stall_o,
  input  logic [XLEN-1:0]           parcel_pc_i,
  input  logic [XLEN-1:0]           parcel_i,
  input  logic [XLEN/16-1:0]        parcel_valid_i,
  input  logic                      parcel_error_i,
  input  logic                      parcel_misaligned_i,
  output logic [31:0]               instr_o,
  output logic [XLEN-1:0]           instr_pc_o,
  output logic                      instr_valid_o,
  output logic                      instr_rvc_o,
  output logic                      instr_error_o,
  output logic                      instr_misaligned_o,
  input  logic                      instr_rd_i
);

  localparam int NP = XLEN / PARCEL_SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(XLEN / 8 - 1);

  logic [PARCEL_SIZE-1:0] parcel_mem [DEPTH];
  logic [XLEN-1:0]        pc_mem     [DEPTH];
  logic [DEPTH-1:0]       err_mem;
  logic [DEPTH-1:0]       mis_mem;

  logic [AW-1:0] rp, wp, sec_idx;
  logic [CW-1:0] cnt, n_push, n_pop;
  logic [AW-1:0] wr_idx [NP];
  logic [XLEN-1:0] base_pc;
  logic head_32, has_one, has_two, pop;

  // Valid parcels are packed densely from wp in ascending lane order.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < NP; k++) begin
      wr_idx[k] = wp + n_push[AW-1:0];
      n_push    = n_push + CW'(parcel_valid_i[k]);
    end
  end

  assign base_pc = parcel_pc_i & ALIGN_MASK;

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int k = 0; k < NP; k++) begin
        if (parcel_valid_i[k]) begin
          parcel_mem[wr_idx[k]] <= parcel_i[PARCEL_SIZE*k +: PARCEL_SIZE];
          pc_mem[wr_idx[k]]     <= base_pc + XLEN'(2 * k);
          err_mem[wr_idx[k]]    <= parcel_error_i;
          mis_mem[wr_idx[k]]    <= parcel_misaligned_i;
        end
      end
    end
  end

  assign has_one = (cnt != '0);
  assign has_two = (cnt >= CW'(2));
  assign sec_idx = rp + AW'(1);
  assign head_32 = (HAS_RVC == 0) || (parcel_mem[rp][1:0] == 2'b11);

  // An erroring head is handed to decode alone so the fault is not held hostage by a missing half.
  assign instr_valid_o      = has_one && (!head_32 || err_mem[rp] || has_two);
  assign instr_rvc_o        = has_one && !head_32;
  assign instr_error_o      = has_one && (err_mem[rp] || (head_32 && has_two && err_mem[sec_idx]));
  assign instr_misaligned_o = has_one && mis_mem[rp];
  assign instr_pc_o         = pc_mem[rp];
  assign instr_o            = head_32 ? {parcel_mem[sec_idx], parcel_mem[rp]}
                                      : {{(32-PARCEL_SIZE){1'b0}}, parcel_mem[rp]};

  assign n_pop   = (head_32 && has_two) ? CW'(2) : CW'(1);
  assign pop     = instr_rd_i && instr_valid_o;
  assign stall_o = (CW'(DEPTH) - cnt) < CW'(NP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (flush_i) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + n_push[AW-1:0];
      if (pop) rp <= rp + n_pop[AW-1:0];
      cnt <= cnt + n_push - (pop ? n_pop : CW'(0));
    end
  end

endmodule

// File: tb/tb_riscv_parcel_queue.sv
// tb/tb_riscv_parcel_queue.sv - directed bench with a parcel-queue model for riscv_parcel_queue
module tb_riscv_parcel_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] parcel_pc = '0;
  logic [31:0] parcel = '0;
  logic [1:0]  parcel_valid = '0;
  logic        parcel_error = 1'b0;
  logic        parcel_mis = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid, instr_rvc, instr_error, instr_mis;
  logic        instr_rd = 1'b0;

  int tests = 0;
  int fails = 0;

  riscv_parcel_queue #(.XLEN(32), .PARCEL_SIZE(16), .HAS_RVC(1), .DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_o(stall),
    .parcel_pc_i(parcel_pc), .parcel_i(parcel), .parcel_valid_i(parcel_valid),
    .parcel_error_i(parcel_error), .parcel_misaligned_i(parcel_mis),
    .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(instr_valid),
    .instr_rvc_o(instr_rvc), .instr_error_o(instr_error),
    .instr_misaligned_o(instr_mis), .instr_rd_i(instr_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [31:0] pc;
    logic        e;
    logic        m;
  } ent_t;

  ent_t q[$];

  function automatic bit m_is32();
    return (q.size() > 0) && (q[0].p[1:0] == 2'b11);
  endfunction

  function automatic bit m_valid();
    if (q.size() == 0) return 1'b0;
    return !m_is32() || q[0].e || (q.size() >= 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instruction-level view of the queue as an ordered list of parcels.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      if (instr_rd && m_valid()) begin
        if (m_is32() && q.size() >= 2) void'(q.pop_front());
        void'(q.pop_front());
      end
      for (int k = 0; k < 2; k++) begin
        if (parcel_valid[k]) begin
          ent_t e;
          e.p  = parcel[16*k +: 16];
          e.pc = (parcel_pc & ~32'h3) + 32'(2 * k);
          e.e  = parcel_error;
          e.m  = parcel_mis;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall", 64'(stall), 64'((8 - q.size()) < 2));
      chk("valid", 64'(instr_valid), 64'(m_valid()));
      if (m_valid()) begin
        chk("pc", 64'(instr_pc), 64'(q[0].pc));
        chk("rvc", 64'(instr_rvc), 64'(!m_is32()));
        chk("error", 64'(instr_error), 64'(q[0].e || (m_is32() && q.size() >= 2 && q[1].e)));
        chk("misaligned", 64'(instr_mis), 64'(q[0].m));
        if (!m_is32())
          chk("instr_rvc_word", 64'(instr), {48'h0, q[0].p});
        else if (q.size() >= 2)
          chk("instr_32_word", 64'(instr), {32'h0, q[1].p, q[0].p});
      end
    end
  end

  task automatic step(input logic [31:0] pc, input logic [31:0] word, input logic [1:0] vld,
                      input logic err, input logic mis, input logic rd, input logic fl);
    parcel_pc    = pc;
    parcel       = word;
    parcel_valid = vld;
    parcel_error = err;
    parcel_mis   = mis;
    instr_rd     = rd;
    flush        = fl;
    if (vld != 2'b00) chk("push_while_stalled", 64'(stall), 64'h0);
    @(negedge clk);
  endtask

  task automatic idle(input logic rd);
    step(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, rd, 1'b0);
  endtask

  initial begin
    #3;
    chk("reset_stall", 64'(stall), 64'h0);
    chk("reset_valid", 64'(instr_valid), 64'h0);
    chk("reset_error", 64'(instr_error), 64'h0);
    chk("reset_mis", 64'(instr_mis), 64'h0);
    chk("reset_rvc", 64'(instr_rvc), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Two RVC parcels drained back to back.
    step(32'h100, 32'h0001_4501, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rvc0_instr", 64'(instr), 64'h4501);
    chk("rvc0_pc", 64'(instr_pc), 64'h100);
    chk("rvc0_rvc", 64'(instr_rvc), 64'h1);
    idle(1'b1);
    chk("rvc1_instr", 64'(instr), 64'h0001);
    chk("rvc1_pc", 64'(instr_pc), 64'h102);
    idle(1'b1);
    chk("rvc_drained", 64'(instr_valid), 64'h0);

    // 32-bit instruction straddling two fetch words.
    step(32'h200, 32'h0513_0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("straddle_wait", 64'(instr_valid), 64'h0);
    step(32'h204, 32'hFFFF_0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("straddle_instr", 64'(instr), 64'h0000_0513);
    chk("straddle_pc", 64'(instr_pc), 64'h202);
    chk("straddle_rvc", 64'(instr_rvc), 64'h0);
    idle(1'b1);
    chk("straddle_pop2", 64'(instr_valid), 64'h0);
    step(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Fill to full, then drain until stall drops.
    for (int i = 0; i < 3; i++)
      step(32'h300 + 32'(4 * i), 32'h0001_0001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill6_stall", 64'(stall), 64'h0);
    step(32'h30C, 32'h0001_0001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill8_stall", 64'(stall), 64'h1);
    idle(1'b1);
    chk("fill7_stall", 64'(stall), 64'h1);
    idle(1'b1);
    chk("fill6b_stall", 64'(stall), 64'h0);
    step(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Walk pointers so a 32-bit instruction lands in slots 7/0.
    step(32'h400, 32'h0000_0001, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(32'h404 + 32'(4 * i), 32'h0001_0001, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32'h500, 32'h0093_0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32'h504, 32'h1111_0000, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("wrap_instr", 64'(instr), 64'h0000_0093);
    chk("wrap_pc", 64'(instr_pc), 64'h502);
    chk("wrap_valid", 64'(instr_valid), 64'h1);
    idle(1'b1);
    chk("wrap_empty", 64'(instr_valid), 64'h0);

    // Lone erroring half of a 32-bit instruction.
    step(32'h600, 32'h0003_0000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_valid", 64'(instr_valid), 64'h1);
    chk("err_flag", 64'(instr_error), 64'h1);
    chk("err_pc", 64'(instr_pc), 64'h602);
    idle(1'b1);
    chk("err_empty", 64'(instr_valid), 64'h0);

    // Misaligned flag travels with the head.
    step(32'h700, 32'h0001_4501, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mis_flag", 64'(instr_mis), 64'h1);
    idle(1'b1);

    // Flush with a concurrent push discards everything.
    step(32'h800, 32'h0001_0001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h804, 32'h0001_0001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h808, 32'h0001_0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h80C, 32'h0001_0001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_valid", 64'(instr_valid), 64'h0);
    chk("flush_stall", 64'(stall), 64'h0);
    step(32'h900, 32'h0001_4501, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_flush_instr", 64'(instr), 64'h4501);
    chk("post_flush_pc", 64'(instr_pc), 64'h900);

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(instr_valid), 64'h0);
    chk("async_rst_rvc", 64'(instr_rvc), 64'h0);
    chk("async_rst_stall", 64'(stall), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    chk("after_rst_valid", 64'(instr_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
